// File: rtl/internal_pkg.sv
// Shared register map, channel FSM state and DFH layout for csr_multi_chan.
// Offsets are word indices, i.e. byte address >> 3.
package internal_pkg;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_e;

   localparam logic [12:0] WADDR_DFH      = 13'h000;
   localparam logic [12:0] WADDR_AFU_ID_L = 13'h001;
   localparam logic [12:0] WADDR_AFU_ID_H = 13'h002;
   localparam logic [12:0] WADDR_CTRL     = 13'h003;
   localparam logic [12:0] WADDR_STATUS   = 13'h004;
   localparam logic [12:0] WADDR_DONE_CLR = 13'h005;
   localparam logic [12:0] WADDR_CH_BASE  = 13'h020;
   localparam int          CH_STRIDE_W    = 8;
   localparam int          CNT_IDX        = 7;

   localparam logic [3:0]  DFH_TYPE_AFU   = 4'h1;

   typedef struct packed {
      logic [3:0]  feat_type;
      logic [18:0] rsvd;
      logic        eol;
      logic [23:0] next_off;
      logic [3:0]  feat_rev;
      logic [11:0] feat_id;
   } dfh_t;

   function automatic logic [63:0] dfh_word(input logic [23:0] next_off);
      dfh_t d;
      d           = '0;
      d.feat_type = DFH_TYPE_AFU;
      d.next_off  = next_off;
      return d;
   endfunction

endpackage

// File: rtl/csr_chan_ctrl.sv
// One template channel: IDLE/RUN FSM, saturating cycle counter, sticky done.
// ch_sync is registered (one cycle after the start write); no backpressure.
module csr_chan_ctrl
   import internal_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic        done_i,
   input  logic        done_clr_i,
   output logic        sync_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] cnt_o
);

   ch_state_e   state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        sync_q, sync_d;
   logic        done_q, done_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CH_IDLE;
         cnt_q   <= '0;
         sync_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sync_q  <= sync_d;
         done_q  <= done_d;
      end
   end

   // A set from done_i overrides a coincident clear.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sync_d  = 1'b0;
      done_d  = done_q & ~done_clr_i;
      case (state_q)
         CH_IDLE: begin
            if (start_i) begin
               state_d = CH_RUN;
               cnt_d   = '0;
               sync_d  = 1'b1;
            end
         end
         CH_RUN: begin
            if (cnt_q != 32'hFFFF_FFFF) begin
               cnt_d = cnt_q + 32'd1;
            end
            if (done_i) begin
               state_d = CH_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = CH_IDLE;
      endcase
   end

   assign sync_o = sync_q;
   assign busy_o = (state_q == CH_RUN);
   assign done_o = done_q;
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/csr_multi_chan.sv
// CCI-P MMIO CSR block: DFH/AFU ID, control/status and per-channel config for NUM_CH channels.
// Read response one cycle after the request, fully pipelined; writes take effect at the next edge.
module csr_multi_chan
   import internal_pkg::*;
#(
   parameter int          NUM_CH   = 4,
   parameter int          CFG_REGS = 2,
   parameter logic [63:0] AFU_ID_L = 64'h0,
   parameter logic [63:0] AFU_ID_H = 64'h0,
   parameter logic [23:0] DFH_NEXT = 24'h001000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           mmio_wr_valid,
   input  logic [15:0]                    mmio_wr_addr,
   input  logic [63:0]                    mmio_wr_data,
   input  logic                           mmio_rd_valid,
   input  logic [15:0]                    mmio_rd_addr,
   input  logic [8:0]                     mmio_rd_tid,
   output logic                           mmio_rsp_valid,
   output logic [8:0]                     mmio_rsp_tid,
   output logic [63:0]                    mmio_rsp_data,
   output logic [NUM_CH-1:0]              ch_sync,
   output logic [NUM_CH*CFG_REGS*64-1:0]  ch_cfg,
   input  logic [NUM_CH-1:0]              ch_done
);

   localparam int CFG_W = NUM_CH * CFG_REGS * 64;

   logic [12:0] wr_waddr, rd_waddr;
   logic [12:0] wr_woff, rd_woff;
   logic        wr_in_ch, rd_in_ch;
   logic        wr_ctrl, wr_clr;
   logic        unused_addr_lsbs;

   assign wr_waddr = mmio_wr_addr[15:3];
   assign rd_waddr = mmio_rd_addr[15:3];
   assign wr_woff  = wr_waddr - WADDR_CH_BASE;
   assign rd_woff  = rd_waddr - WADDR_CH_BASE;
   assign wr_in_ch = (wr_waddr >= WADDR_CH_BASE);
   assign rd_in_ch = (rd_waddr >= WADDR_CH_BASE);
   assign wr_ctrl  = mmio_wr_valid && (wr_waddr == WADDR_CTRL);
   assign wr_clr   = mmio_wr_valid && (wr_waddr == WADDR_DONE_CLR);

   assign unused_addr_lsbs = ^{mmio_wr_addr[2:0], mmio_rd_addr[2:0]};

   logic [NUM_CH-1:0] ch_start, ch_clr, ch_busy, ch_done_st;
   logic [31:0]       ch_cnt [NUM_CH];

   assign ch_start = wr_ctrl ? mmio_wr_data[NUM_CH-1:0] : '0;
   assign ch_clr   = wr_clr  ? mmio_wr_data[NUM_CH-1:0] : '0;

   for (genvar c = 0; c < NUM_CH; c++) begin : gen_chan
      csr_chan_ctrl u_chan (
         .clk        (clk),
         .reset      (reset),
         .start_i    (ch_start[c]),
         .done_i     (ch_done[c]),
         .done_clr_i (ch_clr[c]),
         .sync_o     (ch_sync[c]),
         .busy_o     (ch_busy[c]),
         .done_o     (ch_done_st[c]),
         .cnt_o      (ch_cnt[c])
      );
   end

   logic [CFG_W-1:0] cfg_q, cfg_d;

   always_comb begin
      cfg_d = cfg_q;
      if (mmio_wr_valid && wr_in_ch) begin
         for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < CFG_REGS; k++) begin
               if (wr_woff == 13'(c * CH_STRIDE_W + k)) begin
                  cfg_d[(c*CFG_REGS+k)*64 +: 64] = mmio_wr_data;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_q <= '0;
      end else begin
         cfg_q <= cfg_d;
      end
   end

   assign ch_cfg = cfg_q;

   logic [63:0] status;

   always_comb begin
      status = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         status[c]      = ch_busy[c];
         status[32 + c] = ch_done_st[c];
      end
   end

   // Read data comes from current register state, so a same-cycle write is not yet visible.
   logic [63:0] rd_data_d;

   always_comb begin
      rd_data_d = '0;
      if (rd_in_ch) begin
         for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < CFG_REGS; k++) begin
               if (rd_woff == 13'(c * CH_STRIDE_W + k)) begin
                  rd_data_d = cfg_q[(c*CFG_REGS+k)*64 +: 64];
               end
            end
            if (rd_woff == 13'(c * CH_STRIDE_W + CNT_IDX)) begin
               rd_data_d = {32'h0, ch_cnt[c]};
            end
         end
      end else begin
         case (rd_waddr)
            WADDR_DFH:      rd_data_d = dfh_word(DFH_NEXT);
            WADDR_AFU_ID_L: rd_data_d = AFU_ID_L;
            WADDR_AFU_ID_H: rd_data_d = AFU_ID_H;
            WADDR_STATUS:   rd_data_d = status;
            default:        rd_data_d = '0;
         endcase
      end
   end

   logic        rsp_valid_q;
   logic [8:0]  rsp_tid_q;
   logic [63:0] rsp_data_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_tid_q   <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= mmio_rd_valid;
         if (mmio_rd_valid) begin
            rsp_tid_q  <= mmio_rd_tid;
            rsp_data_q <= rd_data_d;
         end
      end
   end

   assign mmio_rsp_valid = rsp_valid_q;
   assign mmio_rsp_tid   = rsp_tid_q;
   assign mmio_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_csr_multi_chan.sv
// Directed bench for csr_multi_chan: MMIO map, channel FSMs, sticky done and reset behaviour.
module tb_csr_multi_chan;

   localparam int          NUM_CH   = 4;
   localparam int          CFG_REGS = 2;
   localparam logic [63:0] ID_L     = 64'h1122_3344_5566_7788;
   localparam logic [63:0] ID_H     = 64'h99AA_BBCC_DDEE_FF00;
   localparam logic [63:0] DFH_EXP  = 64'h1000_0000_1000_0000;

   logic                          clk = 1'b0;
   logic                          reset;
   logic                          mmio_wr_valid;
   logic [15:0]                   mmio_wr_addr;
   logic [63:0]                   mmio_wr_data;
   logic                          mmio_rd_valid;
   logic [15:0]                   mmio_rd_addr;
   logic [8:0]                    mmio_rd_tid;
   logic                          mmio_rsp_valid;
   logic [8:0]                    mmio_rsp_tid;
   logic [63:0]                   mmio_rsp_data;
   logic [NUM_CH-1:0]             ch_sync;
   logic [NUM_CH*CFG_REGS*64-1:0] ch_cfg;
   logic [NUM_CH-1:0]             ch_done;

   int checks = 0;
   int errors = 0;

   csr_multi_chan #(
      .NUM_CH   (NUM_CH),
      .CFG_REGS (CFG_REGS),
      .AFU_ID_L (ID_L),
      .AFU_ID_H (ID_H),
      .DFH_NEXT (24'h001000)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .mmio_wr_valid  (mmio_wr_valid),
      .mmio_wr_addr   (mmio_wr_addr),
      .mmio_wr_data   (mmio_wr_data),
      .mmio_rd_valid  (mmio_rd_valid),
      .mmio_rd_addr   (mmio_rd_addr),
      .mmio_rd_tid    (mmio_rd_tid),
      .mmio_rsp_valid (mmio_rsp_valid),
      .mmio_rsp_tid   (mmio_rsp_tid),
      .mmio_rsp_data  (mmio_rsp_data),
      .ch_sync        (ch_sync),
      .ch_cfg         (ch_cfg),
      .ch_done        (ch_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [63:0] d);
      mmio_wr_valid = 1'b1;
      mmio_wr_addr  = a;
      mmio_wr_data  = d;
      tick();
      mmio_wr_valid = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [8:0] t,
                     output logic v, output logic [8:0] rt, output logic [63:0] d);
      mmio_rd_valid = 1'b1;
      mmio_rd_addr  = a;
      mmio_rd_tid   = t;
      tick();
      mmio_rd_valid = 1'b0;
      v  = mmio_rsp_valid;
      rt = mmio_rsp_tid;
      d  = mmio_rsp_data;
   endtask

   task automatic pulse_done(input logic [NUM_CH-1:0] m);
      ch_done = m;
      tick();
      ch_done = '0;
   endtask

   task automatic test_reset();
      logic v; logic [8:0] t; logic [63:0] d;
      reset = 1'b1;
      mmio_wr_valid = 1'b0; mmio_wr_addr = '0; mmio_wr_data = '0;
      mmio_rd_valid = 1'b0; mmio_rd_addr = '0; mmio_rd_tid = '0;
      ch_done = '0;
      repeat (3) tick();
      checks++;
      if (ch_sync !== 4'h0 || mmio_rsp_valid !== 1'b0 || ch_cfg !== '0) begin
         errors++; $display("FAIL reset_outputs: sync=%h rsp_valid=%b cfg_nonzero=%b required 0", ch_sync, mmio_rsp_valid, |ch_cfg);
      end
      reset = 1'b0;
      tick();
      rd(16'h0008, 9'd5, v, t, d);
      checks++;
      if (v !== 1'b1 || t !== 9'd5 || d !== ID_L) begin
         errors++; $display("FAIL rd_afu_id_l: valid=%b tid=%0d data=%h required 1/5/%h", v, t, d, ID_L);
      end
      tick();
      checks++;
      if (mmio_rsp_valid !== 1'b0) begin
         errors++; $display("FAIL rsp_single_pulse: valid=%b required 0", mmio_rsp_valid);
      end
      rd(16'h0000, 9'd6, v, t, d);
      checks++;
      if (d !== DFH_EXP) begin
         errors++; $display("FAIL rd_dfh: got %h required %h", d, DFH_EXP);
      end
      rd(16'h0010, 9'd7, v, t, d);
      checks++;
      if (d !== ID_H) begin
         errors++; $display("FAIL rd_afu_id_h: got %h required %h", d, ID_H);
      end
      rd(16'h000D, 9'd8, v, t, d);
      checks++;
      if (d !== ID_L) begin
         errors++; $display("FAIL rd_low_bits_ignored: got %h required %h", d, ID_L);
      end
      rd(16'h0020, 9'd9, v, t, d);
      checks++;
      if (d !== 64'h0) begin
         errors++; $display("FAIL rd_status_after_reset: got %h required 0", d);
      end
   endtask

   task automatic test_start_count();
      logic v; logic [8:0] t; logic [63:0] d;
      wr(16'h0100, 64'hDEAD_BEEF);
      checks++;
      if (ch_cfg[63:0] !== 64'hDEAD_BEEF) begin
         errors++; $display("FAIL cfg_write: got %h required %h", ch_cfg[63:0], 64'hDEAD_BEEF);
      end
      wr(16'h0018, 64'h1);
      checks++;
      if (ch_sync !== 4'b0001) begin
         errors++; $display("FAIL sync_pulse: got %b required 0001", ch_sync);
      end
      tick();
      checks++;
      if (ch_sync !== 4'b0000) begin
         errors++; $display("FAIL sync_one_cycle: got %b required 0000", ch_sync);
      end
      rd(16'h0020, 9'd10, v, t, d);
      checks++;
      if (d !== 64'h1) begin
         errors++; $display("FAIL status_busy: got %h required %h", d, 64'h1);
      end
      repeat (8) tick();
      rd(16'h0138, 9'd11, v, t, d);
      checks++;
      if (d < 64'd10 || d > 64'd12) begin
         errors++; $display("FAIL counter_10: got %0d required 10..12", d);
      end
      wr(16'h0018, 64'h1);
      checks++;
      if (ch_sync !== 4'b0000) begin
         errors++; $display("FAIL start_in_run_sync: got %b required 0000", ch_sync);
      end
      rd(16'h0138, 9'd12, v, t, d);
      checks++;
      if (d < 64'd11 || d > 64'd14) begin
         errors++; $display("FAIL start_in_run_no_clear: got %0d required 11..14", d);
      end
      wr(16'h0108, 64'hCAFE_F00D);
      checks++;
      if (ch_cfg[127:64] !== 64'hCAFE_F00D) begin
         errors++; $display("FAIL cfg_write_in_run: got %h required %h", ch_cfg[127:64], 64'hCAFE_F00D);
      end
      wr(16'h0020, 64'hFFFF_FFFF_FFFF_FFFF);
      rd(16'h0020, 9'd13, v, t, d);
      checks++;
      if (d !== 64'h1) begin
         errors++; $display("FAIL status_read_only: got %h required %h", d, 64'h1);
      end
   endtask

   task automatic test_done_clr();
      logic v; logic [8:0] t; logic [63:0] d;
      pulse_done(4'b0001);
      rd(16'h0020, 9'd14, v, t, d);
      checks++;
      if (d !== 64'h1_0000_0000) begin
         errors++; $display("FAIL status_done: got %h required %h", d, 64'h1_0000_0000);
      end
      wr(16'h0028, 64'h1);
      rd(16'h0020, 9'd15, v, t, d);
      checks++;
      if (d !== 64'h0) begin
         errors++; $display("FAIL done_clr: got %h required 0", d);
      end
   endtask

   task automatic test_done_in_idle();
      logic v; logic [8:0] t; logic [63:0] d;
      pulse_done(4'b0100);
      rd(16'h0020, 9'd16, v, t, d);
      checks++;
      if (d !== 64'h0) begin
         errors++; $display("FAIL done_in_idle: got %h required 0", d);
      end
   endtask

   task automatic test_set_wins();
      logic v; logic [8:0] t; logic [63:0] d;
      wr(16'h0018, 64'h2);
      pulse_done(4'b0010);
      wr(16'h0018, 64'h2);
      ch_done = 4'b0010;
      wr(16'h0028, 64'h2);
      ch_done = '0;
      rd(16'h0020, 9'd17, v, t, d);
      checks++;
      if (d !== 64'h2_0000_0000) begin
         errors++; $display("FAIL set_beats_clr: got %h required %h", d, 64'h2_0000_0000);
      end
      wr(16'h0028, 64'h2);
      rd(16'h0020, 9'd18, v, t, d);
      checks++;
      if (d !== 64'h0) begin
         errors++; $display("FAIL clr_after_set: got %h required 0", d);
      end
   endtask

   task automatic test_start_done_race();
      logic v; logic [8:0] t; logic [63:0] d;
      wr(16'h0018, 64'h1);
      tick();
      ch_done = 4'b0001;
      wr(16'h0018, 64'h1);
      ch_done = '0;
      checks++;
      if (ch_sync !== 4'b0000) begin
         errors++; $display("FAIL race_no_sync: got %b required 0000", ch_sync);
      end
      rd(16'h0020, 9'd19, v, t, d);
      checks++;
      if (d !== 64'h1_0000_0000) begin
         errors++; $display("FAIL race_idle_done: got %h required %h", d, 64'h1_0000_0000);
      end
      wr(16'h0028, 64'hFF);
   endtask

   task automatic test_back_to_back();
      logic [15:0] addrs [4];
      logic [63:0] exps  [4];
      logic v; logic [8:0] t; logic [63:0] d;
      addrs[0] = 16'h0008; exps[0] = ID_L;
      addrs[1] = 16'h0010; exps[1] = ID_H;
      addrs[2] = 16'h0100; exps[2] = 64'hDEAD_BEEF;
      addrs[3] = 16'h03F8; exps[3] = 64'h0;
      for (int i = 0; i < 4; i++) begin
         mmio_rd_valid = 1'b1;
         mmio_rd_addr  = addrs[i];
         mmio_rd_tid   = 9'(i + 1);
         tick();
         checks++;
         if (mmio_rsp_valid !== 1'b1 || mmio_rsp_tid !== 9'(i + 1) || mmio_rsp_data !== exps[i]) begin
            errors++; $display("FAIL b2b_rd%0d: valid=%b tid=%0d data=%h required 1/%0d/%h",
                               i, mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data, i + 1, exps[i]);
         end
      end
      mmio_rd_valid = 1'b0;
      tick();
      checks++;
      if (mmio_rsp_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_end: valid=%b required 0", mmio_rsp_valid);
      end
      rd(16'h0110, 9'd20, v, t, d);
      checks++;
      if (d !== 64'h0) begin
         errors++; $display("FAIL rd_cfg_beyond: got %h required 0", d);
      end
      rd(16'h0200, 9'd21, v, t, d);
      checks++;
      if (d !== 64'h0) begin
         errors++; $display("FAIL rd_chan_beyond: got %h required 0", d);
      end
   endtask

   task automatic test_rd_wr_same();
      logic v; logic [8:0] t; logic [63:0] d;
      mmio_wr_valid = 1'b1; mmio_wr_addr = 16'h0108; mmio_wr_data = 64'h1234;
      mmio_rd_valid = 1'b1; mmio_rd_addr = 16'h0108; mmio_rd_tid = 9'd22;
      tick();
      mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
      checks++;
      if (mmio_rsp_data !== 64'hCAFE_F00D) begin
         errors++; $display("FAIL rd_wr_same_old: got %h required %h", mmio_rsp_data, 64'hCAFE_F00D);
      end
      rd(16'h0108, 9'd23, v, t, d);
      checks++;
      if (d !== 64'h1234) begin
         errors++; $display("FAIL rd_wr_same_new: got %h required %h", d, 64'h1234);
      end
   endtask

   task automatic test_reset_mid_run();
      logic v; logic [8:0] t; logic [63:0] d;
      mmio_wr_valid = 1'b1; mmio_wr_addr = 16'h0018; mmio_wr_data = 64'h1;
      mmio_rd_valid = 1'b1; mmio_rd_addr = 16'h0008; mmio_rd_tid = 9'd24;
      tick();
      mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
      reset = 1'b1;
      #1;
      checks++;
      if (ch_sync !== 4'h0 || mmio_rsp_valid !== 1'b0 || ch_cfg !== '0) begin
         errors++; $display("FAIL async_reset: sync=%h rsp_valid=%b cfg_nonzero=%b required 0", ch_sync, mmio_rsp_valid, |ch_cfg);
      end
      #3;
      reset = 1'b0;
      tick();
      rd(16'h0020, 9'd25, v, t, d);
      checks++;
      if (d !== 64'h0) begin
         errors++; $display("FAIL status_after_abort: got %h required 0", d);
      end
      rd(16'h0100, 9'd26, v, t, d);
      checks++;
      if (d !== 64'h0) begin
         errors++; $display("FAIL cfg_after_abort: got %h required 0", d);
      end
   endtask

   initial begin
      test_reset();
      test_start_count();
      test_done_clr();
      test_done_in_idle();
      test_set_wins();
      test_start_done_race();
      test_back_to_back();
      test_rd_wr_same();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
